// File: rtl/ahb_slave_interface.sv
// AHB-side front end of the AHB-to-APB bridge: transfer qualification, decode, pipelining.
// Optional decode-error response FSM enabled by defining AHB_DECODE_ERR_EN.
module ahb_slave_interface #(
    parameter logic [31:0] BASE_ADDR    = 32'h8000_0000,
    parameter int unsigned REGION_SHIFT = 26,
    parameter int unsigned NUM_SLAVES   = 3
) (
    input  logic        hclk,
    input  logic        hresetn,
    input  logic        hwrite,
    input  logic        hreadyin,
    input  logic [1:0]  htrans,
    input  logic [31:0] haddr,
    input  logic [31:0] hwdata,
    input  logic [31:0] prdata,
    output logic        valid,
    output logic [2:0]  temp_sel,
    output logic [31:0] haddr1,
    output logic [31:0] haddr2,
    output logic [31:0] hwdata1,
    output logic [31:0] hwdata2,
    output logic        hwrite_reg,
    output logic        hwrite_reg1,
    output logic [31:0] hrdata,
    output logic [1:0]  hresp,
    output logic        err_hready
);

    localparam logic [31:0] WIN_SIZE = 32'(NUM_SLAVES) << REGION_SHIFT;

    logic [31:0] offset;
    logic [31:0] region;
    logic        mapped;
    logic        active;

    logic [31:0] haddr1_q;
    logic [31:0] haddr2_q;
    logic [31:0] hwdata1_q;
    logic [31:0] hwdata2_q;
    logic        hwrite1_q;
    logic        hwrite2_q;

    assign offset = haddr - BASE_ADDR;
    assign region = offset >> REGION_SHIFT;
    assign mapped = (haddr >= BASE_ADDR) && (offset < WIN_SIZE);
    assign active = hreadyin & htrans[1];
    assign valid  = active & mapped;
    assign hrdata = prdata;

    always_comb begin
        temp_sel = 3'b000;
        if (mapped) begin
            unique case (1'b1)
                region == 32'd0: temp_sel = 3'b001;
                region == 32'd1: temp_sel = 3'b010;
                region == 32'd2: temp_sel = 3'b100;
                default:         temp_sel = 3'b000;
            endcase
        end
    end

    // Fixed 1/2-cycle delays, deliberately not stalled by hreadyin
    always_ff @(posedge hclk) begin
        if (!hresetn) begin
            haddr1_q  <= '0;
            haddr2_q  <= '0;
            hwdata1_q <= '0;
            hwdata2_q <= '0;
            hwrite1_q <= 1'b0;
            hwrite2_q <= 1'b0;
        end else begin
            haddr1_q  <= haddr;
            haddr2_q  <= haddr1_q;
            hwdata1_q <= hwdata;
            hwdata2_q <= hwdata1_q;
            hwrite1_q <= hwrite;
            hwrite2_q <= hwrite1_q;
        end
    end

    assign haddr1      = haddr1_q;
    assign haddr2      = haddr2_q;
    assign hwdata1     = hwdata1_q;
    assign hwdata2     = hwdata2_q;
    assign hwrite_reg  = hwrite1_q;
    assign hwrite_reg1 = hwrite2_q;

`ifdef AHB_DECODE_ERR_EN
    typedef enum logic [1:0] {
        ST_OK   = 2'b00,
        ST_ERR1 = 2'b01,
        ST_ERR2 = 2'b10
    } err_state_e;

    err_state_e state_q;
    err_state_e state_d;
    logic       err_req;

    assign err_req = active & ~mapped;

    always_ff @(posedge hclk) begin
        if (!hresetn) begin
            state_q <= ST_OK;
        end else begin
            state_q <= state_d;
        end
    end

    // Two-cycle ERROR response; a new error in ERR2 restarts it
    always_comb begin
        state_d    = state_q;
        hresp      = 2'b00;
        err_hready = 1'b1;
        unique case (state_q)
            ST_OK: begin
                if (err_req) state_d = ST_ERR1;
            end
            ST_ERR1: begin
                hresp      = 2'b01;
                err_hready = 1'b0;
                state_d    = ST_ERR2;
            end
            ST_ERR2: begin
                hresp   = 2'b01;
                state_d = err_req ? ST_ERR1 : ST_OK;
            end
            default: state_d = ST_OK;
        endcase
    end
`else
    assign hresp      = 2'b00;
    assign err_hready = 1'b1;
`endif

endmodule

// File: tb/tb_ahb_slave_interface.sv
// Directed self-checking bench for ahb_slave_interface.
// Error-response checks follow AHB_DECODE_ERR_EN.
module tb_ahb_slave_interface;

    logic        hclk;
    logic        hresetn;
    logic        hwrite;
    logic        hreadyin;
    logic [1:0]  htrans;
    logic [31:0] haddr;
    logic [31:0] hwdata;
    logic [31:0] prdata;
    logic        valid;
    logic [2:0]  temp_sel;
    logic [31:0] haddr1;
    logic [31:0] haddr2;
    logic [31:0] hwdata1;
    logic [31:0] hwdata2;
    logic        hwrite_reg;
    logic        hwrite_reg1;
    logic [31:0] hrdata;
    logic [1:0]  hresp;
    logic        err_hready;

    int total;
    int passed;

    ahb_slave_interface dut (
        .hclk       (hclk),
        .hresetn    (hresetn),
        .hwrite     (hwrite),
        .hreadyin   (hreadyin),
        .htrans     (htrans),
        .haddr      (haddr),
        .hwdata     (hwdata),
        .prdata     (prdata),
        .valid      (valid),
        .temp_sel   (temp_sel),
        .haddr1     (haddr1),
        .haddr2     (haddr2),
        .hwdata1    (hwdata1),
        .hwdata2    (hwdata2),
        .hwrite_reg (hwrite_reg),
        .hwrite_reg1(hwrite_reg1),
        .hrdata     (hrdata),
        .hresp      (hresp),
        .err_hready (err_hready)
    );

    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge hclk);
        #1;
    endtask

    task automatic check_err(input string tag, input logic [1:0] r,
                             input logic rdy);
        check({tag, "_hresp"}, 32'(hresp), 32'(r));
        check({tag, "_hready"}, 32'(err_hready), 32'(rdy));
    endtask

    logic [31:0] dec_addr [6];
    logic [2:0]  dec_sel  [6];
    logic        dec_vld  [6];
    logic [1:0]  q_trans  [5];
    logic        q_rdy    [5];
    logic        q_vld    [5];
    logic [31:0] p_addr   [5];
    logic [31:0] p_data   [5];
    logic        p_wr     [5];
    logic [1:0]  p_trans  [5];

    initial begin
        total  = 0;
        passed = 0;
        dec_addr = '{32'h7FFF_FFFF, 32'h8000_0000, 32'h83FF_FFFF,
                     32'h8400_0000, 32'h8BFF_FFFF, 32'h8C00_0000};
        dec_sel  = '{3'b000, 3'b001, 3'b001, 3'b010, 3'b100, 3'b000};
        dec_vld  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        q_trans  = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b10};
        q_rdy    = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        q_vld    = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        p_addr   = '{32'h0000_0000, 32'h8000_0000, 32'h8400_0004,
                     32'h8800_0008, 32'h0000_0000};
        p_data   = '{32'h0, 32'h0, 32'h11, 32'h22, 32'h33};
        p_wr     = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        p_trans  = '{2'b00, 2'b10, 2'b10, 2'b10, 2'b00};

        hresetn  = 1'b0;
        haddr    = 32'hFFFF_FFFF;
        hwdata   = 32'hA5A5_A5A5;
        hwrite   = 1'b1;
        htrans   = 2'b00;
        hreadyin = 1'b1;
        prdata   = 32'h0;
        tick();
        tick();
        check("rst_haddr1", haddr1, 32'h0);
        check("rst_haddr2", haddr2, 32'h0);
        check("rst_hwdata1", hwdata1, 32'h0);
        check("rst_hwdata2", hwdata2, 32'h0);
        check("rst_hwrite_reg", 32'(hwrite_reg), 32'h0);
        check("rst_hwrite_reg1", 32'(hwrite_reg1), 32'h0);
        check_err("rst", 2'b00, 1'b1);

        hresetn = 1'b1;
        haddr   = 32'h0;
        hwrite  = 1'b0;
        tick();

        // Combinational vectors all fit between two clock edges
        htrans = 2'b10;
        for (int i = 0; i < 6; i++) begin
            haddr = dec_addr[i];
            #1;
            check($sformatf("dec_sel%0d", i), 32'(temp_sel), 32'(dec_sel[i]));
            check($sformatf("dec_vld%0d", i), 32'(valid), 32'(dec_vld[i]));
        end
        htrans = 2'b00;
        tick();

        haddr = 32'h8000_0010;
        for (int i = 0; i < 5; i++) begin
            htrans   = q_trans[i];
            hreadyin = q_rdy[i];
            #1;
            check($sformatf("qual%0d", i), 32'(valid), 32'(q_vld[i]));
        end
        htrans   = 2'b00;
        hreadyin = 1'b1;

        prdata = 32'hDEAD_BEEF;
        #1;
        check("rd_return", hrdata, 32'hDEAD_BEEF);
        tick();

        for (int k = 0; k < 5; k++) begin
            haddr  = p_addr[k];
            hwdata = p_data[k];
            hwrite = p_wr[k];
            htrans = p_trans[k];
            tick();
            check($sformatf("p_haddr1_%0d", k), haddr1, p_addr[k]);
            check($sformatf("p_hwdata1_%0d", k), hwdata1, p_data[k]);
            check($sformatf("p_hwr_%0d", k), 32'(hwrite_reg), 32'(p_wr[k]));
            if (k > 0) begin
                check($sformatf("p_haddr2_%0d", k), haddr2, p_addr[k-1]);
                check($sformatf("p_hwdata2_%0d", k), hwdata2, p_data[k-1]);
                check($sformatf("p_hwr1_%0d", k), 32'(hwrite_reg1),
                      32'(p_wr[k-1]));
            end
        end

        hreadyin = 1'b1;
        haddr    = 32'h9000_0000;
        htrans   = 2'b10;
        #1;
        check("unmapped_vld", 32'(valid), 32'h0);
        check("unmapped_sel", 32'(temp_sel), 32'h0);
        tick();
        htrans = 2'b00;
`ifdef AHB_DECODE_ERR_EN
        check_err("err1", 2'b01, 1'b0);
        tick();
        check_err("err2", 2'b01, 1'b1);
        tick();
        check_err("err_ok", 2'b00, 1'b1);

        htrans = 2'b10;
        tick();
        htrans = 2'b00;
        check_err("b2b_err1a", 2'b01, 1'b0);
        tick();
        check_err("b2b_err2a", 2'b01, 1'b1);
        htrans = 2'b10;
        tick();
        htrans = 2'b00;
        check_err("b2b_err1b", 2'b01, 1'b0);
        tick();
        check_err("b2b_err2b", 2'b01, 1'b1);
        tick();
        check_err("b2b_ok", 2'b00, 1'b1);

        htrans = 2'b10;
        tick();
        htrans = 2'b00;
        check_err("rst_err1", 2'b01, 1'b0);
        hresetn = 1'b0;
        tick();
        check_err("rst_mid_err", 2'b00, 1'b1);
        hresetn = 1'b1;
`else
        check_err("noerr_a", 2'b00, 1'b1);
        tick();
        check_err("noerr_b", 2'b00, 1'b1);
`endif
        tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
